// File: rtl/matrix_line_buf_if.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_line_buf_if
//  Brief    : Pixel stream in / window stream out bundle for matrix_line_buf.
//  Revision : 1.0 - initial release
// ============================================================================
interface matrix_line_buf_if #(
    parameter int DATA_WIDTH = 8,
    parameter int KSIZE      = 3,
    parameter int ADDR_WIDTH = 10
);
    logic                              frame_start;
    logic                              in_valid;
    logic [DATA_WIDTH-1:0]             in_data;
    logic                              out_valid;
    logic [KSIZE*KSIZE*DATA_WIDTH-1:0] out_window;
    logic [ADDR_WIDTH-1:0]             out_col;
    logic                              line_err;

    modport master (
        output frame_start, in_valid, in_data,
        input  out_valid, out_window, out_col, line_err
    );

    modport slave (
        input  frame_start, in_valid, in_data,
        output out_valid, out_window, out_col, line_err
    );
endinterface
`default_nettype wire

// File: rtl/matrix_line_buf.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_line_buf
//  Brief    : KSIZE-1 line memories plus a KSIZE x KSIZE window shifter with
//             row/column valid gating; two-cycle latency, no backpressure.
//  Revision : 1.0 - initial release
// ============================================================================
module matrix_line_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int KSIZE      = 3,
    parameter int IMG_WIDTH  = 640,
    parameter int ADDR_WIDTH = 10
) (
    input wire               clk,
    input wire               rst_n,
    matrix_line_buf_if.slave bus
);
    localparam int                    c_NMEM     = KSIZE - 1;
    localparam int                    c_ROW_W    = $clog2(KSIZE);
    localparam int                    c_WIN_W    = KSIZE * KSIZE * DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_LAST_COL = ADDR_WIDTH'(IMG_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] c_MIN_COL  = ADDR_WIDTH'(KSIZE - 1);
    localparam logic [c_ROW_W-1:0]    c_ROW_MAX  = c_ROW_W'(KSIZE - 1);

    logic [ADDR_WIDTH-1:0] r_col;
    logic [ADDR_WIDTH-1:0] w_col_cur;
    logic [c_ROW_W-1:0]    r_row;
    logic [c_ROW_W-1:0]    w_row_cur;
    logic                  r_line_err;

    logic [DATA_WIDTH-1:0] r_mem [c_NMEM][IMG_WIDTH];
    logic [DATA_WIDTH-1:0] r_rd  [c_NMEM];

    logic                  r_s1_valid;
    logic [DATA_WIDTH-1:0] r_s1_data;
    logic [ADDR_WIDTH-1:0] r_s1_col;
    logic [c_ROW_W-1:0]    r_s1_row;

    logic [DATA_WIDTH-1:0] w_new_col [KSIZE];
    logic [c_WIN_W-1:0]    r_window;
    logic                  r_out_valid;
    logic [ADDR_WIDTH-1:0] r_out_col;

    // frame_start retargets the pixel accepted in the same cycle to (0,0)
    always_comb begin
        w_col_cur = bus.frame_start ? '0 : r_col;
        w_row_cur = bus.frame_start ? '0 : r_row;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col      <= '0;
            r_row      <= '0;
            r_line_err <= 1'b0;
        end else begin
            if (bus.frame_start && (r_col != '0)) begin
                r_line_err <= 1'b1;
            end
            if (bus.in_valid) begin
                if (w_col_cur == c_LAST_COL) begin
                    r_col <= '0;
                    r_row <= (w_row_cur == c_ROW_MAX) ? w_row_cur : w_row_cur + 1'b1;
                end else begin
                    r_col <= w_col_cur + 1'b1;
                    r_row <= w_row_cur;
                end
            end else begin
                r_col <= w_col_cur;
                r_row <= w_row_cur;
            end
        end
    end

    // Read-before-write cascade: each line moves one memory deeper per visit
    always_ff @(posedge clk) begin
        if (rst_n && bus.in_valid) begin
            for (int k = 0; k < c_NMEM; k++) begin
                r_rd[k] <= r_mem[k][w_col_cur];
            end
            r_mem[0][w_col_cur] <= bus.in_data;
            for (int k = 1; k < c_NMEM; k++) begin
                r_mem[k][w_col_cur] <= r_mem[k-1][w_col_cur];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_col   <= '0;
            r_s1_row   <= '0;
        end else begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_data <= bus.in_data;
                r_s1_col  <= w_col_cur;
                r_s1_row  <= w_row_cur;
            end
        end
    end

    // Top row of the new column is the oldest line memory
    always_comb begin
        for (int r = 0; r < KSIZE - 1; r++) begin
            w_new_col[r] = r_rd[KSIZE-2-r];
        end
        w_new_col[KSIZE-1] = r_s1_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_window    <= '0;
            r_out_valid <= 1'b0;
            r_out_col   <= '0;
        end else begin
            r_out_valid <= r_s1_valid && (r_s1_row >= c_ROW_MAX) && (r_s1_col >= c_MIN_COL);
            if (r_s1_valid) begin
                r_out_col <= r_s1_col;
                for (int r = 0; r < KSIZE; r++) begin
                    for (int c = 0; c < KSIZE - 1; c++) begin
                        r_window[((r*KSIZE)+c)*DATA_WIDTH +: DATA_WIDTH] <=
                            r_window[((r*KSIZE)+c+1)*DATA_WIDTH +: DATA_WIDTH];
                    end
                    r_window[((r*KSIZE)+KSIZE-1)*DATA_WIDTH +: DATA_WIDTH] <= w_new_col[r];
                end
            end
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.out_window = r_window;
    assign bus.out_col    = r_out_col;
    assign bus.line_err   = r_line_err;

endmodule
`default_nettype wire

// File: tb/tb_matrix_line_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_matrix_line_buf
//  Brief    : Self-checking bench for matrix_line_buf (3x3/8-bit and 5x5/12-bit
//             instances) against a whole-image window reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_line_buf;
    localparam int c_MAXC = 512;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    matrix_line_buf_if #(.DATA_WIDTH(8),  .KSIZE(3), .ADDR_WIDTH(10)) bus_a ();
    matrix_line_buf_if #(.DATA_WIDTH(12), .KSIZE(5), .ADDR_WIDTH(10)) bus_b ();

    matrix_line_buf #(.DATA_WIDTH(8), .KSIZE(3), .IMG_WIDTH(4), .ADDR_WIDTH(10)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    matrix_line_buf #(.DATA_WIDTH(12), .KSIZE(5), .IMG_WIDTH(6), .ADDR_WIDTH(10)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int n_checks = 0;
    int n_fails  = 0;
    int cyc;
    int sel;

    // Expected / observed per sample index (sample k taken 1 ns after posedge k)
    bit           exp_v [c_MAXC];
    logic [299:0] exp_w [c_MAXC];
    int           exp_c [c_MAXC];
    bit           exp_e [c_MAXC];
    logic         obs_v [c_MAXC];
    logic [299:0] obs_w [c_MAXC];
    int           obs_c [c_MAXC];
    logic         obs_e [c_MAXC];

    // Reference model: whole-frame image store, one per instance
    int m_row [2];
    int m_col [2];
    bit m_err [2];
    int img   [2][64][8];

    task automatic clear_log();
        cyc = 0;
        for (int i = 0; i < c_MAXC; i++) begin
            exp_v[i] = 1'b0; exp_w[i] = '0; exp_c[i] = 0; exp_e[i] = 1'b0;
            obs_v[i] = 1'b0; obs_w[i] = '0; obs_c[i] = 0; obs_e[i] = 1'b0;
        end
    endtask

    task automatic step(input bit fs, input bit v, input int din, input bit rlo);
        int k, w, dwd, d, mr, mc;
        logic [299:0] win;
        k   = (sel != 0) ? 5 : 3;
        w   = (sel != 0) ? 6 : 4;
        dwd = (sel != 0) ? 12 : 8;
        d   = din & ((1 << dwd) - 1);

        rst_n             = !rlo;
        bus_a.frame_start = (sel == 0) && fs;
        bus_a.in_valid    = (sel == 0) && v;
        bus_a.in_data     = 8'(d);
        bus_b.frame_start = (sel != 0) && fs;
        bus_b.in_valid    = (sel != 0) && v;
        bus_b.in_data     = 12'(d);

        if (rlo) begin
            for (int s = 0; s < 2; s++) begin
                m_row[s] = 0; m_col[s] = 0; m_err[s] = 1'b0;
            end
            exp_v[cyc+1] = 1'b0;
        end else begin
            if (fs) begin
                if (m_col[sel] != 0) m_err[sel] = 1'b1;
                m_row[sel] = 0;
                m_col[sel] = 0;
            end
            if (v) begin
                mr = m_row[sel];
                mc = m_col[sel];
                img[sel][mr][mc] = d;
                if (mr >= k - 1 && mc >= k - 1) begin
                    win = '0;
                    for (int r = 0; r < k; r++)
                        for (int c = 0; c < k; c++)
                            win = win | (300'(img[sel][mr-k+1+r][mc-k+1+c]) << (((r * k) + c) * dwd));
                    exp_v[cyc+2] = 1'b1;
                    exp_w[cyc+2] = win;
                    exp_c[cyc+2] = mc;
                end
                if (mc == w - 1) begin
                    m_col[sel] = 0;
                    if (mr < 63) m_row[sel] = mr + 1;
                end else begin
                    m_col[sel] = mc + 1;
                end
            end
        end

        @(posedge clk);
        cyc = cyc + 1;
        exp_e[cyc] = m_err[sel];
        #1;
        obs_v[cyc] = (sel != 0) ? bus_b.out_valid : bus_a.out_valid;
        obs_w[cyc] = (sel != 0) ? 300'(bus_b.out_window) : 300'(bus_a.out_window);
        obs_c[cyc] = (sel != 0) ? int'(bus_b.out_col) : int'(bus_a.out_col);
        obs_e[cyc] = (sel != 0) ? bus_b.line_err : bus_a.line_err;
    endtask

    task automatic test_reset();
        sel = 0;
        clear_log();
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        n_checks += 4;
        if (bus_a.out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_a_valid got %b exp 0", bus_a.out_valid); end
        if (bus_a.out_window !== '0) begin n_fails++; $display("FAIL reset_a_window got %h exp 0", bus_a.out_window); end
        if (bus_a.out_col !== '0) begin n_fails++; $display("FAIL reset_a_col got %0d exp 0", bus_a.out_col); end
        if (bus_a.line_err !== 1'b0) begin n_fails++; $display("FAIL reset_a_err got %b exp 0", bus_a.line_err); end
        n_checks += 4;
        if (bus_b.out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_b_valid got %b exp 0", bus_b.out_valid); end
        if (bus_b.out_window !== '0) begin n_fails++; $display("FAIL reset_b_window got %h exp 0", bus_b.out_window); end
        if (bus_b.out_col !== '0) begin n_fails++; $display("FAIL reset_b_col got %0d exp 0", bus_b.out_col); end
        if (bus_b.line_err !== 1'b0) begin n_fails++; $display("FAIL reset_b_err got %b exp 0", bus_b.line_err); end
    endtask

    task automatic test_basic();
        int np, first, last;
        logic [299:0] e1, e2;
        int v1 [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        int v2 [9] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
        sel = 0;
        clear_log();
        step(1, 0, 0, 0);
        for (int p = 0; p < 16; p++) step(0, 1, p, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        np = 0; first = -1; last = -1;
        for (int i = 1; i <= cyc; i++) begin
            n_checks++;
            if (obs_v[i] !== exp_v[i]) begin n_fails++; $display("FAIL basic_valid s%0d got %b exp %b", i, obs_v[i], exp_v[i]); end
            if (exp_v[i]) begin
                n_checks++;
                if (obs_w[i] !== exp_w[i] || obs_c[i] != exp_c[i]) begin
                    n_fails++; $display("FAIL basic_window s%0d got %h/%0d exp %h/%0d", i, obs_w[i], obs_c[i], exp_w[i], exp_c[i]);
                end
            end
            if (obs_v[i] === 1'b1) begin np++; if (first < 0) first = i; last = i; end
        end
        e1 = '0; e2 = '0;
        for (int j = 0; j < 9; j++) begin
            e1 = e1 | (300'(v1[j]) << (j * 8));
            e2 = e2 | (300'(v2[j]) << (j * 8));
        end
        n_checks += 5;
        if (np != 4) begin n_fails++; $display("FAIL basic_count got %0d exp 4", np); end
        // pixel 10 is accepted at posedge 12, so its window is sampled after posedge 13
        if (first != 13) begin n_fails++; $display("FAIL basic_first_time got %0d exp 13", first); end
        if (first < 0 || obs_w[first] !== e1) begin n_fails++; $display("FAIL basic_first_window got %h exp %h", (first < 0) ? '0 : obs_w[first], e1); end
        if (first < 0 || obs_c[first] != 2) begin n_fails++; $display("FAIL basic_first_col got %0d exp 2", (first < 0) ? -1 : obs_c[first]); end
        if (last < 0 || obs_w[last] !== e2) begin n_fails++; $display("FAIL basic_last_window got %h exp %h", (last < 0) ? '0 : obs_w[last], e2); end
    endtask

    task automatic test_gaps();
        int np;
        sel = 0;
        clear_log();
        step(1, 0, 0, 0);
        for (int p = 0; p < 16; p++) begin
            step(0, 1, p, 0);
            step(0, 0, 0, 0);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        np = 0;
        for (int i = 1; i <= cyc; i++) begin
            n_checks++;
            if (obs_v[i] !== exp_v[i]) begin n_fails++; $display("FAIL gaps_valid s%0d got %b exp %b", i, obs_v[i], exp_v[i]); end
            if (exp_v[i]) begin
                n_checks++;
                if (obs_w[i] !== exp_w[i] || obs_c[i] != exp_c[i]) begin
                    n_fails++; $display("FAIL gaps_window s%0d got %h/%0d exp %h/%0d", i, obs_w[i], obs_c[i], exp_w[i], exp_c[i]);
                end
            end
            if (obs_v[i] === 1'b1) np++;
        end
        n_checks++;
        if (np != 4) begin n_fails++; $display("FAIL gaps_count got %0d exp 4", np); end
    endtask

    task automatic test_5x5();
        int np, first;
        sel = 1;
        clear_log();
        step(1, 0, 0, 0);
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 6; c++) step(0, 1, r * 16 + c, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        np = 0; first = -1;
        for (int i = 1; i <= cyc; i++) begin
            n_checks++;
            if (obs_v[i] !== exp_v[i]) begin n_fails++; $display("FAIL k5_valid s%0d got %b exp %b", i, obs_v[i], exp_v[i]); end
            if (exp_v[i]) begin
                n_checks++;
                if (obs_w[i] !== exp_w[i] || obs_c[i] != exp_c[i]) begin
                    n_fails++; $display("FAIL k5_window s%0d got %h/%0d exp %h/%0d", i, obs_w[i], obs_c[i], exp_w[i], exp_c[i]);
                end
            end
            if (obs_v[i] === 1'b1) begin np++; if (first < 0) first = i; end
        end
        n_checks += 3;
        if (np != 6) begin n_fails++; $display("FAIL k5_count got %0d exp 6", np); end
        if (first < 0 || obs_w[first][12*12 +: 12] !== 12'h022) begin
            n_fails++; $display("FAIL k5_centre got %h exp 022", (first < 0) ? 12'h0 : obs_w[first][12*12 +: 12]);
        end
        if (first < 0 || obs_w[first][24*12 +: 12] !== 12'h044) begin
            n_fails++; $display("FAIL k5_bottom_right got %h exp 044", (first < 0) ? 12'h0 : obs_w[first][24*12 +: 12]);
        end
    endtask

    task automatic test_back_to_back();
        int np1, np2;
        sel = 0;
        clear_log();
        for (int f = 0; f < 2; f++)
            for (int p = 0; p < 16; p++) step(p == 0, 1, int'($urandom), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        np1 = 0; np2 = 0;
        for (int i = 1; i <= cyc; i++) begin
            n_checks++;
            if (obs_v[i] !== exp_v[i]) begin n_fails++; $display("FAIL b2b_valid s%0d got %b exp %b", i, obs_v[i], exp_v[i]); end
            if (exp_v[i]) begin
                n_checks++;
                if (obs_w[i] !== exp_w[i] || obs_c[i] != exp_c[i]) begin
                    n_fails++; $display("FAIL b2b_window s%0d got %h/%0d exp %h/%0d", i, obs_w[i], obs_c[i], exp_w[i], exp_c[i]);
                end
            end
            // frame 2 pixel 0 is accepted at posedge 17; its windows appear from sample 18
            if (obs_v[i] === 1'b1) begin if (i >= 18) np2++; else np1++; end
        end
        n_checks += 2;
        if (np1 != 4) begin n_fails++; $display("FAIL b2b_count1 got %0d exp 4", np1); end
        if (np2 != 4) begin n_fails++; $display("FAIL b2b_count2 got %0d exp 4", np2); end
    endtask

    task automatic test_partial_line();
        int np;
        sel = 0;
        clear_log();
        step(1, 1, int'($urandom), 0);
        step(0, 1, int'($urandom), 0);
        for (int p = 0; p < 16; p++) step(p == 0, 1, int'($urandom), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        np = 0;
        for (int i = 1; i <= cyc; i++) begin
            n_checks += 2;
            if (obs_v[i] !== exp_v[i]) begin n_fails++; $display("FAIL partial_valid s%0d got %b exp %b", i, obs_v[i], exp_v[i]); end
            if (obs_e[i] !== exp_e[i]) begin n_fails++; $display("FAIL partial_err s%0d got %b exp %b", i, obs_e[i], exp_e[i]); end
            if (exp_v[i]) begin
                n_checks++;
                if (obs_w[i] !== exp_w[i] || obs_c[i] != exp_c[i]) begin
                    n_fails++; $display("FAIL partial_window s%0d got %h/%0d exp %h/%0d", i, obs_w[i], obs_c[i], exp_w[i], exp_c[i]);
                end
            end
            if (obs_v[i] === 1'b1) np++;
        end
        n_checks += 2;
        if (np != 4) begin n_fails++; $display("FAIL partial_count got %0d exp 4", np); end
        if (obs_e[cyc] !== 1'b1) begin n_fails++; $display("FAIL partial_sticky got %b exp 1", obs_e[cyc]); end
    endtask

    task automatic test_reset_mid();
        int np, ridx;
        sel = 0;
        clear_log();
        step(1, 0, 0, 0);
        for (int p = 0; p < 10; p++) step(0, 1, p, 0);
        step(0, 0, 0, 1);
        ridx = cyc;
        step(0, 1, 10, 0);
        step(0, 1, 11, 0);
        for (int p = 0; p < 16; p++) step(p == 0, 1, int'($urandom), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        n_checks += 4;
        if (obs_v[ridx] !== 1'b0) begin n_fails++; $display("FAIL rstmid_valid got %b exp 0", obs_v[ridx]); end
        if (obs_w[ridx] !== '0) begin n_fails++; $display("FAIL rstmid_window got %h exp 0", obs_w[ridx]); end
        if (obs_c[ridx] != 0) begin n_fails++; $display("FAIL rstmid_col got %0d exp 0", obs_c[ridx]); end
        if (obs_e[ridx] !== 1'b0) begin n_fails++; $display("FAIL rstmid_err got %b exp 0", obs_e[ridx]); end
        np = 0;
        for (int i = 1; i <= cyc; i++) begin
            n_checks++;
            if (obs_v[i] !== exp_v[i]) begin n_fails++; $display("FAIL rstmid_seq_valid s%0d got %b exp %b", i, obs_v[i], exp_v[i]); end
            if (exp_v[i]) begin
                n_checks++;
                if (obs_w[i] !== exp_w[i] || obs_c[i] != exp_c[i]) begin
                    n_fails++; $display("FAIL rstmid_window s%0d got %h/%0d exp %h/%0d", i, obs_w[i], obs_c[i], exp_w[i], exp_c[i]);
                end
            end
            if (obs_v[i] === 1'b1) np++;
        end
        n_checks++;
        if (np != 4) begin n_fails++; $display("FAIL rstmid_count got %0d exp 4", np); end
    endtask

    task automatic test_random();
        int k, w, h;
        for (int it = 0; it < 4; it++) begin
            sel = int'($urandom_range(0, 1));
            k = (sel != 0) ? 5 : 3;
            w = (sel != 0) ? 6 : 4;
            h = int'($urandom_range(k, k + 3));
            clear_log();
            for (int p = 0; p < h * w; p++) begin
                step(p == 0, 1, int'($urandom), 0);
                for (int g = int'($urandom_range(0, 2)); g > 0; g--) step(0, 0, 0, 0);
            end
            for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
            for (int i = 1; i <= cyc; i++) begin
                n_checks++;
                if (obs_v[i] !== exp_v[i]) begin n_fails++; $display("FAIL rand%0d_valid s%0d got %b exp %b", it, i, obs_v[i], exp_v[i]); end
                if (exp_v[i]) begin
                    n_checks++;
                    if (obs_w[i] !== exp_w[i] || obs_c[i] != exp_c[i]) begin
                        n_fails++; $display("FAIL rand%0d_window s%0d got %h/%0d exp %h/%0d", it, i, obs_w[i], obs_c[i], exp_w[i], exp_c[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        rst_n             = 1'b0;
        bus_a.frame_start = 1'b0; bus_a.in_valid = 1'b0; bus_a.in_data = '0;
        bus_b.frame_start = 1'b0; bus_b.in_valid = 1'b0; bus_b.in_data = '0;
        for (int s = 0; s < 2; s++) begin
            m_row[s] = 0; m_col[s] = 0; m_err[s] = 1'b0;
        end
        test_reset();
        test_basic();
        test_gaps();
        test_5x5();
        test_back_to_back();
        test_partial_line();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/matrix_line_buf.md
# matrix_line_buf

Parametrised single-clock line buffer and window generator for the filter pipeline, including the Gaussian filter. It accepts a raster pixel stream and stores the previous KSIZE-1 lines in internal line memories. It emits a full KSIZE×KSIZE pixel window for every input pixel whose window lies entirely inside the frame. It supersedes the fixed 8-bit, fixed-depth, two-clock FIFO line stage with one block that is generic in pixel width, line length and kernel size, and adds frame-aware valid gating.

## Interface
Parameters:
- DATA_WIDTH, 8, pixel width in bits (1–32)
- KSIZE, 3, window size; legal values 3 and 5
- IMG_WIDTH, 640, pixels per line (≥ KSIZE, ≤ 2^ADDR_WIDTH)
- ADDR_WIDTH, 10, column counter and line memory address width

Ports:
- clk  in  1  clock; the only clock of this block
- rst_n  in  1  reset, synchronous, active-low
- frame_start  in  1  single-cycle pulse at the start of a frame; clears the row and column counters
- in_valid  in  1  in_data is accepted this cycle
- in_data  in  DATA_WIDTH  raster-order pixel
- out_valid  out  1  out_window holds a valid window this cycle
- out_window  out  KSIZE*KSIZE*DATA_WIDTH  window; element (r,c) at bits [((r*KSIZE)+c)*DATA_WIDTH +: DATA_WIDTH]; r=0 is the oldest (top) row, c=0 the leftmost column
- out_col  out  ADDR_WIDTH  column of the newest pixel in the window (bottom-right)
- line_err  out  1  sticky; set when frame_start arrives with col ≠ 0 (partial line)

## Operation
Counters and line memories:
- col counts 0..IMG_WIDTH-1 and advances on every accepted in_valid.
- At IMG_WIDTH-1, col wraps to 0 and row increments.
- row saturates at KSIZE-1; rows beyond that need no distinct count.
- There are KSIZE-1 line memories, each IMG_WIDTH deep with synchronous read, all addressed by col.
- On an accepted pixel, memory k reads address col, then writes the value read from memory k-1 (memory 0 writes in_data). This is read-before-write: the read value is the old content.
- Memory contents are never cleared. Stale data is masked by the row gating.

Pipeline:
- Stage 1 registers in_valid, in_data, col and row while the memory reads resolve.
- Stage 2, when stage-1 valid is high, shifts the window registers left by one column. The new right column is {mem[KSIZE-2] out, …, mem[0] out, stage-1 data}, ordered top to bottom.
- Window registers hold their value when no pixel is in flight.

Output gating:
- out_valid = stage-2 valid AND row ≥ KSIZE-1 AND col ≥ KSIZE-1, using the row and col of that pixel.
- No border padding is applied. Each frame produces (H-KSIZE+1)×(IMG_WIDTH-KSIZE+1) windows.

Frame control:
- frame_start forces col=0 and row=0.
- If in_valid is high in the same cycle, that pixel is (row 0, col 0) of the new frame.
- Pixels already in the pipeline complete with their own gating.
- line_err is set if frame_start arrives with col ≠ 0. It is cleared only by rst_n.

## Timing
- Latency is 2 cycles: a pixel accepted in cycle t produces its out_valid and out_window in cycle t+2.
- Throughput is one pixel per cycle. Arbitrary in_valid gaps are allowed, including gaps within a line.
- out_valid is a single-cycle pulse per qualifying pixel. There is no backpressure; the downstream block must accept every window.
- Reset (rst_n=0 at a clk edge) clears col, row, line_err, stage valids, out_valid, out_window and out_col to 0.
- Reset mid-frame discards all in-flight pixels. The next pixel is treated as row 0, col 0 even if frame_start is absent.
- Column wrap and frame_start in the same cycle: frame_start wins and row goes to 0.
- Row saturation means any frame height ≥ KSIZE works without a height parameter.

## Test plan
- Basic 3×3 window:
  - Stimulus: KSIZE=3, IMG_WIDTH=4, frame_start, then pixels 0..15 contiguous.
  - Required: 4 out_valid pulses.
  - First pulse is 2 cycles after pixel 10, with out_window rows {0,1,2},{4,5,6},{8,9,10} and out_col=2.
  - Last pulse has window {5,6,7},{9,10,11},{13,14,15}.
- Input gaps: same stream with in_valid deasserted every other cycle → identical 4 windows in identical order, each exactly 2 cycles after its pixel.
- 5×5 window:
  - Stimulus: KSIZE=5, IMG_WIDTH=6, DATA_WIDTH=12, 7 lines of value row*16+col.
  - Required: 6 pulses.
  - First window centre = 0x22 (row 2, col 2); bottom-right element = 0x44.
- Back-to-back frames: frame_start immediately after the last pixel, second frame of 16 new values → no window mixes frame-1 data; exactly 4 pulses in frame 2.
- Partial line: frame_start after 2 pixels of a line → line_err=1 and stays high; the new frame still produces its correct 4 windows.
- Reset mid-frame: rst_n low for 1 cycle after pixel 9 → out_valid never pulses for pixels 10/11; all outputs read 0 the cycle after reset; a following full frame yields the 4 correct windows.
